// File: rtl/uart8_receiver.sv
// 8-bit UART receiver: oversampled start/data/parity/stop recovery.
// Good bytes go to the rx FIFO; framing, parity and overrun errors are pulsed.
module uart8_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_rx,
    input  logic       i_is_fifo_full,
    output logic [7:0] o_out,
    output logic       o_fifo_wr_en,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_perr;
    logic [7:0]             r_out;
    logic                   r_wr;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_fe;
    logic                   r_pe;
    logic                   r_ov;

    logic w_rx_s;
    logic w_tick;
    logic w_par_exp;

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_tick = (r_cnt == C_FULL);

    always_comb begin
        w_par_exp = 1'b0;
        case (PARITY_MODE)
            1:       w_par_exp = r_par;
            2:       w_par_exp = ~r_par;
            3:       w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_out     <= '0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            r_fe   <= 1'b0;
            r_pe   <= 1'b0;
            r_ov   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_en && !w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // mid-start-bit: all later samples are whole bits from here
                            r_state   <= S_DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_par     <= 1'b0;
                            r_perr    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_par   <= r_par ^ w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_perr  <= (w_rx_s != w_par_exp);
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_done <= 1'b1;
                        if (!w_rx_s) begin
                            r_fe    <= 1'b1;
                            r_state <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (r_perr) begin
                                r_pe <= 1'b1;
                            end else if (i_is_fifo_full) begin
                                r_ov <= 1'b1;
                            end else begin
                                r_wr  <= 1'b1;
                                r_out <= r_shift;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // a held-low line must go idle before another start counts
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_out        = r_out;
    assign o_fifo_wr_en = r_wr;
    assign o_done       = r_done;
    assign o_busy       = r_busy;
    assign o_frame_err  = r_fe;
    assign o_parity_err = r_pe;
    assign o_overrun    = r_ov;

endmodule

// File: tb/tb_uart8_receiver.sv
// Randomised frame bench for uart8_receiver (no parity and even parity).
// Outcomes come from a frame-level model; a monitor queues every pulse.
module tb_uart8_receiver;

    localparam int OS   = 16;
    localparam int SYNC = 2;

    localparam logic [3:0] K_WR = 4'b1000;
    localparam logic [3:0] K_FE = 4'b0100;
    localparam logic [3:0] K_PE = 4'b0010;
    localparam logic [3:0] K_OV = 4'b0001;

    typedef struct {
        int         cyc;
        logic [4:0] flags;
        logic [7:0] out;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic full = 1'b0;

    logic [7:0] out0, out1;
    logic wr0, done0, busy0, fe0, pe0, ov0;
    logic wr1, done1, busy1, fe1, pe1, ov1;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    ev_t q0[$];
    ev_t q1[$];
    logic [7:0] last_out[2];

    uart8_receiver #(.OVERSAMPLE(OS), .PARITY_MODE(0), .SYNC_STAGES(SYNC)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx0),
        .i_is_fifo_full(full), .o_out(out0), .o_fifo_wr_en(wr0),
        .o_done(done0), .o_busy(busy0), .o_frame_err(fe0),
        .o_parity_err(pe0), .o_overrun(ov0)
    );

    uart8_receiver #(.OVERSAMPLE(OS), .PARITY_MODE(1), .SYNC_STAGES(SYNC)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx1),
        .i_is_fifo_full(full), .o_out(out1), .o_fifo_wr_en(wr1),
        .o_done(done1), .o_busy(busy1), .o_frame_err(fe1),
        .o_parity_err(pe1), .o_overrun(ov1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (wr0 | done0 | fe0 | pe0 | ov0)) begin
            e.cyc = cyc;
            e.flags = {done0, wr0, fe0, pe0, ov0};
            e.out = out0;
            q0.push_back(e);
        end
        if (!rst && (wr1 | done1 | fe1 | pe1 | ov1)) begin
            e.cyc = cyc;
            e.flags = {done1, wr1, fe1, pe1, ov1};
            e.out = out1;
            q1.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic drive(input int d, input logic v, input int n);
        set_rx(d, v);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] model_kind(input int d, input logic [7:0] data,
                                              input logic pbit, input logic stop,
                                              input logic fl);
        if (!stop) return K_FE;
        if (d == 1 && pbit != ^data) return K_PE;
        if (fl) return K_OV;
        return K_WR;
    endfunction

    function automatic int model_cyc(input int d, input int c0);
        return c0 + 1 + SYNC + OS / 2 + (9 + d) * OS;
    endfunction

    task automatic send_frame(input int d, input logic [7:0] data,
                              input logic pbit, input logic stop,
                              input logic fl, input logic endrop,
                              output int c0);
        c0 = cyc;
        full = fl;
        drive(d, 1'b0, OS);
        if (endrop) en = 1'b0;
        for (int i = 0; i < 8; i++) drive(d, data[i], OS);
        if (d == 1) drive(d, pbit, OS);
        drive(d, stop, OS);
        full = 1'b0;
        if (endrop) en = 1'b1;
    endtask

    task automatic expect_ev(input int d, input logic [3:0] kind,
                             input logic [7:0] data, input int ecyc,
                             output int gcyc);
        ev_t e;
        int  sz;
        gcyc = -1;
        sz = (d == 0) ? q0.size() : q1.size();
        chk("ev_present", (sz != 0), 1);
        if (sz != 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (kind == K_WR) last_out[d] = data;
            chk("ev_kind", e.flags, {1'b1, kind});
            chk("ev_cyc", e.cyc, ecyc);
            chk("ev_out", e.out, last_out[d]);
            gcyc = e.cyc;
        end
    endtask

    task automatic expect_none(input int d);
        int sz;
        sz = (d == 0) ? q0.size() : q1.size();
        chk("no_extra_ev", sz, 0);
        if (d == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic run_frame(input int d, input logic [7:0] data,
                             input logic pbit, input logic stop,
                             input logic fl, input logic endrop,
                             input int gap);
        int c0, g;
        send_frame(d, data, pbit, stop, fl, endrop, c0);
        expect_ev(d, model_kind(d, data, pbit, stop, fl), data,
                  model_cyc(d, c0), g);
        idle(gap);
        expect_none(d);
    endtask

    initial begin
        int c0, c1, g0, g1;
        logic [7:0] rd;
        last_out[0] = 8'h00;
        last_out[1] = 8'h00;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out0", {out0, wr0, done0, busy0, fe0, pe0, ov0}, 0);
        chk("rst_out1", {out1, wr1, done1, busy1, fe1, pe1, ov1}, 0);
        idle(5);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        expect_ev(0, K_WR, 8'hA5, model_cyc(0, c0), g0);
        chk("lat_a5", g0 - c0 - 1, 154);
        idle(6);
        expect_none(0);

        run_frame(1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        run_frame(1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 6);

        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, c0);
        expect_ev(0, K_FE, 8'h55, model_cyc(0, c0), g0);
        drive(0, 1'b0, 400);
        chk("break_busy", busy0, 1);
        expect_none(0);
        idle(6);
        run_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 6);

        drive(0, 1'b0, 5);
        chk("glitch_busy", busy0, 1);
        idle(30);
        chk("glitch_idle", busy0, 0);
        expect_none(0);

        run_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        chk("ovr_out_held", out0, 8'h11);

        en = 1'b0;
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        idle(20);
        expect_none(0);
        en = 1'b1;

        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, c1);
        expect_ev(0, K_WR, 8'h00, model_cyc(0, c0), g0);
        expect_ev(0, K_WR, 8'hFF, model_cyc(0, c1), g1);
        chk("b2b_gap", g1 - g0, 160);
        idle(6);
        expect_none(0);

        send_frame(0, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        expect_ev(0, K_WR, 8'h5C, model_cyc(0, c0), g0);
        drive(0, 1'b0, OS);
        for (int i = 0; i < 4; i++) drive(0, i[0], OS);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        chk("midrst_out0", {out0, wr0, done0, busy0, fe0, pe0, ov0}, 0);
        rst = 1'b0;
        last_out[0] = 8'h00;
        last_out[1] = 8'h00;
        idle(200);
        expect_none(0);
        expect_none(1);

        for (int n = 0; n < 40; n++) begin
            int   d;
            logic st, pb, fl, ed;
            d  = $urandom_range(0, 1);
            rd = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            pb = (^rd) ^ ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 3) == 0);
            ed = 1'($urandom_range(0, 1));
            run_frame(d, rd, pb, st, fl, ed, $urandom_range(4, 20));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
